// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader: FSM state encoding
// and the constant log2 used to size the beat index.
package fifo_stream_reader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  // Ceiling log2 with a floor of 1 bit so a 2-beat burst still gets an index.
  function automatic int clog2_f(input int value);
    int res_v;
    res_v = 1;
    for (int i = 30; i >= 1; i--) begin
      if ((32'sd1 << i) >= value) begin
        res_v = i;
      end else begin
        res_v = res_v;
      end
    end
    return res_v;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO first-word-fall-through read port plus the outgoing valid/ready stream.
// master = the reader block, slave = FIFO/downstream side.
interface fifo_stream_reader_if #(
  parameter int DATA_SIZE = 8
);
  logic                 empty;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_en;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    input  empty, r_data, out_ready,
    output r_en, out_data, out_valid, out_last
  );

  modport slave (
    output empty, r_data, out_ready,
    input  r_en, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry skid buffer: an output register backed by one skid register, so
// a pop issued while downstream stalls is never lost.
module stream_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic [1:0]       occ_r;
  logic [1:0]       occ_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             valid_r;
  logic             xfer_s;

  assign xfer_s    = valid_r && out_ready;
  assign out_valid = valid_r;
  assign out_data  = head_r;
  assign occ       = occ_r;

  // Next occupancy and entry contents from push/transfer in the current cycle.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = head_r;
    skid_nxt_s = skid_r;
    case (occ_r)
      2'd0: begin
        if (push) begin
          head_nxt_s = push_data;
          occ_nxt_s  = 2'd1;
        end else begin
          occ_nxt_s  = 2'd0;
        end
      end
      2'd1: begin
        if (push && xfer_s) begin
          head_nxt_s = push_data;
        end else if (push) begin
          skid_nxt_s = push_data;
          occ_nxt_s  = 2'd2;
        end else if (xfer_s) begin
          occ_nxt_s  = 2'd0;
        end else begin
          occ_nxt_s  = 2'd1;
        end
      end
      2'd2: begin
        // Pops are blocked while full, so only a transfer can change state here.
        if (xfer_s) begin
          head_nxt_s = skid_r;
          occ_nxt_s  = 2'd1;
        end else begin
          occ_nxt_s  = 2'd2;
        end
      end
      default: begin
        occ_nxt_s = 2'd0;
      end
    endcase
  end

  // Buffer state registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r   <= 2'd0;
      head_r  <= '0;
      skid_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      occ_r   <= occ_nxt_s;
      head_r  <= head_nxt_s;
      skid_r  <= skid_nxt_s;
      valid_r <= (occ_nxt_s != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: pops FWFT words in fixed-length bursts and
// presents them on a registered valid/ready stream with a last-beat marker.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic                             r_clk,
  input  logic                             r_rst_n,
  input  logic                             rd_enable,
  fifo_stream_reader_if.master             bus,
  output logic                             busy,
  output logic [clog2_f(BURST_LEN)-1:0]    beat_idx,
  output logic [CNT_W-1:0]                 word_count
);

  localparam int               IDX_W    = clog2_f(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  rd_state_e            state_r;
  rd_state_e            state_nxt_s;
  logic [IDX_W-1:0]     beat_r;
  logic [IDX_W-1:0]     beat_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 pop_s;
  logic                 final_pop_s;
  logic                 xfer_s;
  logic [1:0]           occ_s;
  logic                 valid_s;
  logic [DATA_SIZE:0]   head_s;

  // Pop only when a word is present, a burst is open and the buffer has room.
  assign pop_s       = !bus.empty && (state_r == BURST) && (occ_s != 2'd2);
  assign final_pop_s = pop_s && (beat_r == LAST_IDX);
  assign xfer_s      = valid_s && bus.out_ready;

  assign bus.r_en      = pop_s;
  assign bus.out_valid = valid_s;
  assign bus.out_last  = head_s[DATA_SIZE];
  assign bus.out_data  = head_s[DATA_SIZE-1:0];
  assign busy          = (state_r == BURST) || (occ_s != 2'd0);
  assign beat_idx      = beat_r;
  assign word_count    = cnt_r;

  stream_skid_buf #(
    .WIDTH (DATA_SIZE + 1)
  ) u_skid (
    .clk       (r_clk),
    .rst_n     (r_rst_n),
    .push      (pop_s),
    .push_data ({final_pop_s, bus.r_data}),
    .out_ready (bus.out_ready),
    .out_valid (valid_s),
    .out_data  (head_s),
    .occ       (occ_s)
  );

  // Burst framing; rd_enable only matters when no burst is in progress.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      IDLE: begin
        if (rd_enable && !bus.empty) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (final_pop_s) begin
          beat_nxt_s  = '0;
          state_nxt_s = rd_enable ? BURST : IDLE;
        end else if (pop_s) begin
          beat_nxt_s  = beat_r + IDX_W'(1);
        end else begin
          beat_nxt_s  = beat_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        beat_nxt_s  = '0;
      end
    endcase
  end

  // FSM state and beat index registers.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_r <= IDLE;
      beat_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
    end
  end

  // Accepted-handshake counter, wrapping naturally at its width.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      cnt_r <= '0;
    end else if (xfer_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO modelled as a queue,
// expected output stream kept as a queue of {last, data} words.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          r_clk = 1'b0;
  logic          r_rst_n = 1'b0;
  logic          rd_enable = 1'b0;
  logic          busy;
  logic [1:0]    beat_idx;
  logic [CW-1:0] word_count;

  fifo_stream_reader_if #(.DATA_SIZE(DW)) bus ();

  fifo_stream_reader #(
    .DATA_SIZE (DW),
    .BURST_LEN (BL),
    .CNT_W     (CW)
  ) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .rd_enable  (rd_enable),
    .bus        (bus),
    .busy       (busy),
    .beat_idx   (beat_idx),
    .word_count (word_count)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0]  fifo_q[$];
  logic [8:0]  exp_q[$];
  int          pops;
  int          xfers;
  int          checks;
  int          errors;
  logic        pre_ren;
  logic        pre_xfer;
  logic [31:0] last_mask;

  typedef struct {
    logic       push_en;
    logic [7:0] push_val;
    logic       rd_en;
    logic       rdy;
    logic       exp_ren;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.empty  = (fifo_q.size() == 0);
    bus.r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  // Mid-cycle: compare DUT against the reference stream, note handshakes.
  task automatic sample();
    @(negedge r_clk);
    check("pop_while_empty", 32'(bus.r_en && bus.empty), 32'd0);
    check("valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
      check("last", 32'(bus.out_last), 32'(exp_q[0][8]));
    end
    check("beat_idx", 32'(beat_idx), 32'(pops % BL));
    check("word_count", 32'(word_count), 32'(xfers % 16));
    if (exp_q.size() != 0 || (pops % BL) != 0) check("busy", 32'(busy), 32'd1);
    if (bus.r_en) check("pop_room", 32'(exp_q.size() < 2), 32'd1);
    pre_ren  = bus.r_en;
    pre_xfer = bus.out_valid && bus.out_ready;
    if (pre_xfer && bus.out_last && xfers < 32) last_mask[xfers] = 1'b1;
  endtask

  // Clock edge: apply the pop/transfer seen mid-cycle to the models.
  task automatic advance();
    logic [7:0] w;
    @(posedge r_clk);
    #1;
    if (pre_ren && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      exp_q.push_back({((pops % BL) == (BL - 1)), w});
      pops++;
    end
    if (pre_xfer && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      xfers++;
    end
    pre_ren  = 1'b0;
    pre_xfer = 1'b0;
    drive_fifo();
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    r_rst_n       = 1'b0;
    rd_enable     = 1'b0;
    bus.out_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    pops      = 0;
    xfers     = 0;
    last_mask = 32'd0;
    pre_ren   = 1'b0;
    pre_xfer  = 1'b0;
    drive_fifo();
    repeat (2) @(posedge r_clk);
    #1;
    r_rst_n = 1'b1;
  endtask

  task automatic run_until_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      cyc();
      n++;
    end
    check("timeout_pops", 32'(pops >= target), 32'd1);
  endtask

  task automatic run_until_xfers(input int target, input int budget);
    int n;
    n = 0;
    while (xfers < target && n < budget) begin
      cyc();
      n++;
    end
    check("timeout_xfers", 32'(xfers >= target), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    //            push  val    rd    rdy   ren   vld   data   last  busy
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset with FIFO empty: every output at zero.
    bus.out_ready = 1'b0;
    drive_fifo();
    #2;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_ren", 32'(bus.r_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_beat", 32'(beat_idx), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);

    // Asynchronous reset mid-burst with one word buffered.
    do_reset();
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    rd_enable = 1'b1;
    cyc();
    cyc();
    check("mid_valid_before", 32'(bus.out_valid), 32'd1);
    check("mid_beat_before", 32'(beat_idx), 32'd1);
    #2;
    r_rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check("async_beat", 32'(beat_idx), 32'd0);
    check("async_ren", 32'(bus.r_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);

    // Table-driven single burst of four words.
    do_reset();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    for (int i = 0; i < 9; i++) begin
      rd_enable     = vecs[i].rd_en;
      bus.out_ready = vecs[i].rdy;
      if (vecs[i].push_en) push_word(vecs[i].push_val);
      sample();
      check("tbl_ren", 32'(bus.r_en), 32'(vecs[i].exp_ren));
      check("tbl_valid", 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check("tbl_data", 32'(bus.out_data), 32'(vecs[i].exp_data));
        check("tbl_last", 32'(bus.out_last), 32'(vecs[i].exp_last));
      end
      check("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
      advance();
    end

    // Backpressure: two pops fill the buffer, nothing lost afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'h31 + 8'(i));
    rd_enable = 1'b1;
    repeat (8) cyc();
    check("bp_pops", 32'(pops), 32'd2);
    check("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
    check("bp_hold", 32'(bus.out_data), 32'h31);
    bus.out_ready = 1'b1;
    run_until_xfers(5, 40);
    check("bp_drained", 32'(fifo_q.size()), 32'd0);

    // rd_enable dropped mid-burst: burst completes, then IDLE.
    do_reset();
    for (int i = 0; i < 7; i++) push_word(8'h60 + 8'(i));
    rd_enable     = 1'b1;
    bus.out_ready = 1'b1;
    run_until_pops(2, 20);
    rd_enable = 1'b0;
    repeat (10) cyc();
    check("drop_pops", 32'(pops), 32'd4);
    check("drop_fifo_left", 32'(fifo_q.size()), 32'd3);
    check("drop_xfers", 32'(xfers), 32'd4);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_last_mask", last_mask, 32'h8);

    // FIFO runs dry mid-burst, refills six cycles later.
    do_reset();
    push_word(8'h81);
    push_word(8'h82);
    rd_enable     = 1'b1;
    bus.out_ready = 1'b1;
    run_until_pops(2, 20);
    repeat (6) begin
      sample();
      check("gap_ren", 32'(bus.r_en), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      advance();
    end
    push_word(8'h83);
    push_word(8'h84);
    run_until_xfers(4, 20);
    check("gap_pops", 32'(pops), 32'd4);
    check("gap_last_mask", last_mask, 32'h8);
    rd_enable = 1'b0;

    // 17-word stream: counter wraps, last on every fourth transfer.
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'(i + 1));
    rd_enable     = 1'b1;
    bus.out_ready = 1'b1;
    run_until_xfers(17, 60);
    check("wrap_count", 32'(word_count), 32'd1);
    check("wrap_last_mask", last_mask, 32'h8888);

    // Randomised traffic against the reference stream.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 20) push_word(8'($urandom));
      rd_enable     = ($urandom_range(0, 7) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    check("rand_progress", 32'(xfers > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
